// File: rtl/mux_nto1_stream.sv
// mux_nto1_stream: registered N:1 valid/ready stream mux with explicit-select or round-robin arbitration and packet lock
//   clk, rst_n          : rising-edge clock, asynchronous active-low reset
//   mode, sel           : 0 = grant channel sel, 1 = round-robin from rr_ptr
//   in_data             : N channels, channel i at bits [i*W +: W]
//   in_valid, in_last   : per-channel beat valid and last-beat-of-packet
//   in_ready            : per-channel accept, combinational, at most one bit set
//   out_data/out_valid/out_last/out_chan : registered held beat and its source channel
//   out_ready           : consumer accept
module mux_nto1_stream #(
   parameter int N = 4,
   parameter int W = 8,
   localparam int SELW = $clog2(N)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              mode,
   input  logic [SELW-1:0]   sel,
   input  logic [N*W-1:0]    in_data,
   input  logic [N-1:0]      in_valid,
   input  logic [N-1:0]      in_last,
   output logic [N-1:0]      in_ready,
   output logic [W-1:0]      out_data,
   output logic              out_valid,
   output logic              out_last,
   output logic [SELW-1:0]   out_chan,
   input  logic              out_ready
);
   typedef enum logic {IDLE, LOCKED} state_t;
   localparam logic [SELW:0]   NUM     = (SELW + 1)'(N);
   localparam logic [SELW-1:0] LAST_CH = SELW'(N - 1);
   state_t          state_q, state_d;
   logic [SELW-1:0] lock_chan_q, lock_chan_d;
   logic [SELW-1:0] rr_ptr_q, rr_ptr_d;
   logic [SELW-1:0] out_chan_q, out_chan_d;
   logic [W-1:0]    out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;
   logic            out_last_q, out_last_d;
   logic            pkt_rr_q, pkt_rr_d;
   logic [SELW-1:0] g;
   logic [W-1:0]    g_data;
   logic            g_last, grant_ok, rr_found, load_en, xfer, rr_now;
   // Grant candidate: locked channel, explicit select, or first valid channel at/after rr_ptr
   always_comb begin
      g = sel;
      grant_ok = 1'b0;
      rr_found = 1'b0;
      if (state_q == LOCKED) begin
         g = lock_chan_q;
         grant_ok = in_valid[lock_chan_q];
      end else if (!mode) begin
         grant_ok = ({1'b0, sel} < NUM) && in_valid[sel];
      end else begin
         for (int k = 0; k < N; k++) begin
            if (!rr_found && in_valid[(int'(rr_ptr_q) + k) % N]) begin
               rr_found = 1'b1;
               g = SELW'((int'(rr_ptr_q) + k) % N);
            end
         end
         grant_ok = rr_found;
      end
   end
   always_comb begin
      g_data = in_data[int'(g) * W +: W];
      g_last = in_last[g];
      load_en = !out_valid_q || out_ready;
      xfer = rst_n && load_en && grant_ok;
      in_ready = '0;
      for (int i = 0; i < N; i++) in_ready[i] = xfer && (int'(g) == i);
      // a packet follows round-robin rules if it started in mode 1, whatever mode says now
      rr_now = (state_q == IDLE) ? mode : pkt_rr_q;
      out_valid_d = load_en ? xfer : out_valid_q;
      out_data_d = xfer ? g_data : out_data_q;
      out_last_d = xfer ? g_last : out_last_q;
      out_chan_d = xfer ? g : out_chan_q;
      state_d = xfer ? (g_last ? IDLE : LOCKED) : state_q;
      lock_chan_d = (xfer && state_q == IDLE) ? g : lock_chan_q;
      pkt_rr_d = (xfer && state_q == IDLE) ? mode : pkt_rr_q;
      rr_ptr_d = (xfer && g_last && rr_now) ? ((g == LAST_CH) ? '0 : g + SELW'(1)) : rr_ptr_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         lock_chan_q <= '0;
         rr_ptr_q <= '0;
         pkt_rr_q <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q <= '0;
         out_last_q <= 1'b0;
         out_chan_q <= '0;
      end else begin
         state_q <= state_d;
         lock_chan_q <= lock_chan_d;
         rr_ptr_q <= rr_ptr_d;
         pkt_rr_q <= pkt_rr_d;
         out_valid_q <= out_valid_d;
         out_data_q <= out_data_d;
         out_last_q <= out_last_d;
         out_chan_q <= out_chan_d;
      end
   end
   assign out_data = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last = out_last_q;
   assign out_chan = out_chan_q;
endmodule

// File: tb/tb_mux_nto1_stream.sv
// tb_mux_nto1_stream: directed and randomized checks of mux_nto1_stream against a behavioural model and scoreboard
module tb_mux_nto1_stream;
   localparam int N = 4;
   localparam int W = 8;
   logic clk = 0;
   logic rst_n = 0;
   logic mode = 0;
   logic [1:0] sel = 0;
   logic [N*W-1:0] in_data = 0;
   logic [N-1:0] in_valid = 0, in_last = 0, in_ready;
   logic [W-1:0] out_data;
   logic out_valid, out_last, out_ready = 1;
   logic [1:0] out_chan;
   logic mode3 = 0;
   logic [1:0] sel3 = 0;
   logic [23:0] in_data3 = 0;
   logic [2:0] in_valid3 = 0, in_last3 = 0, in_ready3;
   logic [7:0] out_data3;
   logic out_valid3, out_last3, out_ready3 = 1;
   logic [1:0] out_chan3;
   int errors = 0;
   int checks = 0;
   int m_ov, m_od, m_ol, m_oc, m_lock, m_lch, m_rr, m_pkt_rr;
   typedef struct {int chan; int data; int last;} beat_t;
   beat_t sb[$];
   mux_nto1_stream #(.N(N), .W(W)) dut (
      .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .in_data(in_data), .in_valid(in_valid),
      .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready));
   mux_nto1_stream #(.N(3), .W(8)) dut3 (
      .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3), .in_data(in_data3), .in_valid(in_valid3),
      .in_last(in_last3), .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
      .out_last(out_last3), .out_chan(out_chan3), .out_ready(out_ready3));
   always #5 clk = ~clk;
   function automatic int m_grant();
      int r;
      r = -1;
      if (m_lock != 0) r = in_valid[m_lch] ? m_lch : -1;
      else if (!mode) r = (sel < N && in_valid[sel]) ? int'(sel) : -1;
      else for (int k = N - 1; k >= 0; k--) if (in_valid[(m_rr + k) % N]) r = (m_rr + k) % N;
      return r;
   endfunction
   function automatic logic [N-1:0] m_ready();
      int g;
      logic [N-1:0] one;
      g = m_grant();
      one = 1;
      return (g >= 0 && (m_ov == 0 || out_ready)) ? one << g : '0;
   endfunction
   task automatic model_reset();
      m_ov = 0; m_od = 0; m_ol = 0; m_oc = 0; m_lock = 0; m_lch = 0; m_rr = 0; m_pkt_rr = 0;
      sb.delete();
   endtask
   task automatic tick();
      int g, rrm;
      g = m_grant();
      if (m_ov == 0 || out_ready) begin
         if (g < 0) m_ov = 0;
         else begin
            rrm = (m_lock != 0) ? m_pkt_rr : int'(mode);
            if (m_lock == 0) m_pkt_rr = int'(mode);
            m_ov = 1;
            m_od = int'(in_data[g*W +: W]);
            m_ol = int'(in_last[g]);
            m_oc = g;
            if (in_last[g]) begin
               m_lock = 0;
               if (rrm != 0) m_rr = (g + 1) % N;
            end else begin
               m_lock = 1;
               m_lch = g;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      rst_n = 0; in_valid = 4'hF; in_last = 4'hF; out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 4'h0) begin errors++; $display("FAIL reset_in_ready: got %b want 0000", in_ready); end
      checks++;
      if ({out_valid, out_last, out_chan, out_data} !== 12'h0) begin
         errors++; $display("FAIL reset_out: got v=%b l=%b c=%0d d=%h want all zero", out_valid, out_last, out_chan, out_data);
      end
      rst_n = 1;
      model_reset();
      mode = 0; sel = 2; in_data = 32'h00A5_0000; in_valid = 4'b0100; in_last = 4'b0100;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL first_ready: got %b want 0100", in_ready); end
      tick();
      checks++;
      if (out_data !== 8'hA5 || out_chan !== 2'd2 || out_valid !== 1'b1 || out_last !== 1'b1) begin
         errors++; $display("FAIL first_beat: got d=%h c=%0d v=%b l=%b want d=a5 c=2 v=1 l=1", out_data, out_chan, out_valid, out_last);
      end
      in_valid = 0;
      tick();
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL first_drain: got v=%b want 0", out_valid); end
   endtask
   task automatic test_select();
      mode = 0; sel = 3; in_valid = 4'hF; in_last = 4'hF; in_data = 32'h3C2B_1A09;
      #1;
      checks++;
      if (in_ready !== 4'b1000) begin errors++; $display("FAIL sel3_ready: got %b want 1000", in_ready); end
      tick();
      checks++;
      if (out_chan !== 2'd3 || out_data !== 8'h3C) begin errors++; $display("FAIL sel3_out: got c=%0d d=%h want c=3 d=3c", out_chan, out_data); end
      sel = 0;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL sel0_ready: got %b want 0001", in_ready); end
      tick();
      checks++;
      if (out_chan !== 2'd0 || out_data !== 8'h09) begin errors++; $display("FAIL sel0_out: got c=%0d d=%h want c=0 d=09", out_chan, out_data); end
      in_valid = 0;
      tick();
      sel3 = 1; in_valid3 = 3'b111; in_last3 = 3'b111; in_data3 = 24'h77_55_33;
      #1;
      checks++;
      if (in_ready3 !== 3'b010) begin errors++; $display("FAIL n3_sel1_ready: got %b want 010", in_ready3); end
      tick();
      checks++;
      if (out_valid3 !== 1'b1 || out_data3 !== 8'h55 || out_chan3 !== 2'd1) begin
         errors++; $display("FAIL n3_sel1_out: got v=%b d=%h c=%0d want v=1 d=55 c=1", out_valid3, out_data3, out_chan3);
      end
      sel3 = 3;
      #1;
      checks++;
      if (in_ready3 !== 3'b000) begin errors++; $display("FAIL n3_bad_sel_ready: got %b want 000", in_ready3); end
      repeat (2) tick();
      checks++;
      if (out_valid3 !== 1'b0 || in_ready3 !== 3'b000) begin
         errors++; $display("FAIL n3_bad_sel_drain: got v=%b r=%b want v=0 r=000", out_valid3, in_ready3);
      end
      in_valid3 = 0;
   endtask
   task automatic test_round_robin();
      logic [7:0] exp_d;
      mode = 1; in_valid = 4'hF; in_last = 4'hF; out_ready = 1;
      for (int k = 0; k < 6; k++) begin
         in_data = $urandom;
         #1;
         checks++;
         if (in_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d]: got %b want ch%0d", k, in_ready, k % 4); end
         exp_d = in_data[(k % 4)*W +: W];
         tick();
         checks++;
         if (out_chan !== 2'(k % 4) || out_data !== exp_d || out_valid !== 1'b1) begin
            errors++; $display("FAIL rr_out[%0d]: got c=%0d d=%h v=%b want c=%0d d=%h v=1", k, out_chan, out_data, out_valid, k % 4, exp_d);
         end
      end
      in_valid = 0;
      tick();
   endtask
   task automatic test_packet_lock();
      logic [7:0] exp_d;
      mode = 1; in_valid = 4'b0001; in_last = 4'b0001; in_data = $urandom;
      tick();
      in_valid = 4'b0111; in_last = 4'b0000;
      for (int b = 0; b < 3; b++) begin
         in_data = $urandom;
         if (b == 1) begin mode = 0; sel = 0; end
         if (b == 2) in_last = 4'b0010;
         #1;
         checks++;
         if (in_ready !== 4'b0010) begin errors++; $display("FAIL lock_ready[%0d]: got %b want 0010", b, in_ready); end
         exp_d = in_data[W +: W];
         tick();
         checks++;
         if (out_chan !== 2'd1 || out_data !== exp_d || out_last !== (b == 2)) begin
            errors++; $display("FAIL lock_out[%0d]: got c=%0d d=%h l=%b want c=1 d=%h l=%0d", b, out_chan, out_data, out_last, exp_d, b == 2);
         end
      end
      mode = 1; in_valid = 4'b0101; in_last = 4'b0101;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL lock_next_ready: got %b want 0100", in_ready); end
      tick();
      checks++;
      if (out_chan !== 2'd2) begin errors++; $display("FAIL lock_next_out: got c=%0d want c=2", out_chan); end
      in_valid = 0;
      tick();
   endtask
   task automatic test_backpressure();
      logic [11:0] held;
      logic [7:0] exp_d;
      mode = 0; sel = 1; in_valid = 4'b0010; in_last = 4'b0010; in_data = $urandom; out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_ready: got %b want 0010", in_ready); end
      exp_d = in_data[W +: W];
      tick();
      held = {out_valid, out_last, out_chan, out_data};
      checks++;
      if (held !== {1'b1, 1'b1, 2'd1, exp_d}) begin errors++; $display("FAIL bp_first_out: got %h want %h", held, {1'b1, 1'b1, 2'd1, exp_d}); end
      out_ready = 0;
      in_data = $urandom;
      exp_d = in_data[W +: W];
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (in_ready !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b want 0000", k, in_ready); end
         tick();
         checks++;
         if ({out_valid, out_last, out_chan, out_data} !== held) begin
            errors++; $display("FAIL bp_stall_hold[%0d]: got %h want %h", k, {out_valid, out_last, out_chan, out_data}, held);
         end
      end
      out_ready = 1;
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready: got %b want 0010", in_ready); end
      tick();
      checks++;
      if (out_data !== exp_d || out_valid !== 1'b1) begin errors++; $display("FAIL bp_release_out: got d=%h v=%b want d=%h v=1", out_data, out_valid, exp_d); end
      in_valid = 0;
      tick();
   endtask
   task automatic test_reset_mid_packet();
      mode = 1; in_valid = 4'b1000; in_last = 4'b0000; out_ready = 1;
      for (int b = 0; b < 2; b++) begin
         in_data = $urandom;
         tick();
      end
      checks++;
      if (out_valid !== 1'b1 || out_chan !== 2'd3) begin errors++; $display("FAIL mid_pre: got v=%b c=%0d want v=1 c=3", out_valid, out_chan); end
      rst_n = 0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000) begin errors++; $display("FAIL mid_reset: got v=%b r=%b want v=0 r=0000", out_valid, in_ready); end
      @(posedge clk);
      #1;
      rst_n = 1;
      model_reset();
      mode = 0; sel = 2; in_valid = 4'b0100; in_last = 4'b0100;
      #1;
      checks++;
      if (in_ready !== 4'b0100) begin errors++; $display("FAIL mid_unlocked: got %b want 0100", in_ready); end
      tick();
      mode = 1; in_valid = 4'hF; in_last = 4'hF;
      #1;
      checks++;
      if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_rr_ptr: got %b want 0001", in_ready); end
      tick();
      checks++;
      if (out_chan !== 2'd0) begin errors++; $display("FAIL mid_rr_out: got c=%0d want c=0", out_chan); end
      in_valid = 0;
      tick();
   endtask
   task automatic test_random();
      beat_t b;
      logic [11:0] exp_o;
      for (int n = 0; n < 400; n++) begin
         mode = 1'($urandom_range(0, 1));
         sel = 2'($urandom);
         in_valid = 4'($urandom);
         in_last = 4'($urandom & $urandom);
         in_data = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++;
         if (in_ready !== m_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, m_ready()); end
         if (out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
               errors++; $display("FAIL rand_sb[%0d]: got beat c=%0d d=%h want none", n, out_chan, out_data);
            end else begin
               b = sb.pop_front();
               if (out_chan !== 2'(b.chan) || out_data !== 8'(b.data) || out_last !== 1'(b.last)) begin
                  errors++; $display("FAIL rand_sb[%0d]: got c=%0d d=%h l=%b want c=%0d d=%h l=%0d", n, out_chan, out_data, out_last, b.chan, b.data, b.last);
               end
            end
         end
         for (int i = 0; i < N; i++) if (in_valid[i] && in_ready[i]) sb.push_back('{i, int'(in_data[i*W +: W]), int'(in_last[i])});
         tick();
         exp_o = {1'(m_ov), 1'(m_ol), 2'(m_oc), 8'(m_od)};
         checks++;
         if ({out_valid, out_last, out_chan, out_data} !== exp_o) begin
            errors++; $display("FAIL rand_out[%0d]: got %h want %h", n, {out_valid, out_last, out_chan, out_data}, exp_o);
         end
      end
   endtask
   initial begin
      model_reset();
      test_reset();
      test_select();
      test_round_robin();
      test_packet_lock();
      test_backpressure();
      test_reset_mid_packet();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
